sram_fb_port: RTL and testbench



---
 rtl/sram_fb_port.sv | 197 +++++++++++++++++++
 tb/tb_sram_fb_port.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fb_port.sv
// Single-port SRAM framebuffer engine: time-shares the SRAM between scan-out reads and queued pixel writes.
// Optional screen fill engine is built when FB_CLEAR_EN is defined.
module sram_fb_port #(
  parameter int X_W         = 10,
  parameter int Y_W         = 10,
  parameter int SCALE_SHIFT = 1,
  parameter int FIFO_DEPTH  = 8,
  localparam int XS_W   = X_W - SCALE_SHIFT,
  localparam int YS_W   = Y_W - SCALE_SHIFT,
  localparam int ADDR_W = XS_W + YS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_en,
  input  logic [X_W-1:0]    disp_x,
  input  logic [Y_W-1:0]    disp_y,
  output logic [9:0]        disp_r,
  output logic [9:0]        disp_g,
  output logic [9:0]        disp_b,
  output logic              disp_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [XS_W-1:0]   wr_x,
  input  logic [YS_W-1:0]   wr_y,
  input  logic [15:0]       wr_data,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [15:0]       sram_dq,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  input  logic              clear,
  input  logic [15:0]       clear_color,
  output logic              clear_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + 16;

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_CLEAR, SLOT_WRITE} slot_t;
  slot_t slot_next;

  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] last_rd_reg;
  logic              en_d1_reg;
  logic              disp_valid_reg;
  logic [15:0]       pix_reg;
  logic [ADDR_W-1:0] sram_addr_reg;
  logic              we_n_reg;
  logic              oe_n_reg;
  logic [15:0]       dq_out_reg;
  logic              dq_oe_reg;
  logic [ADDR_W-1:0] clr_addr;
  logic [15:0]       clr_color;
  logic              unused_bits;

  assign disp_addr = {disp_x[X_W-1:SCALE_SHIFT], disp_y[Y_W-1:SCALE_SHIFT]};

  // Write FIFO; one extra pointer bit distinguishes full from empty.
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] fifo_head;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                      (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign wr_ready   = !fifo_full && !clear_busy;
  assign push       = wr_valid && wr_ready;
  assign pop        = (slot_next == SLOT_WRITE);
  assign fifo_head  = fifo_mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= {wr_x, wr_y, wr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

`ifdef FB_CLEAR_EN
  logic              clear_busy_reg;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic [15:0]       clr_color_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_busy_reg <= 1'b0;
      clr_addr_reg   <= '0;
      clr_color_reg  <= '0;
    end else if (clear_busy_reg) begin
      if (slot_next == SLOT_CLEAR) begin
        clr_addr_reg <= clr_addr_reg + 1'b1;
        if (&clr_addr_reg) clear_busy_reg <= 1'b0;
      end
    end else if (clear) begin
      clear_busy_reg <= 1'b1;
      clr_addr_reg   <= '0;
      clr_color_reg  <= clear_color;
    end
  end

  assign clear_busy  = clear_busy_reg;
  assign clr_addr    = clr_addr_reg;
  assign clr_color   = clr_color_reg;
  assign unused_bits = &{1'b0, disp_x, disp_y, pix_reg[15]};
`else
  assign clear_busy  = 1'b0;
  assign clr_addr    = '0;
  assign clr_color   = '0;
  assign unused_bits = &{1'b0, disp_x, disp_y, pix_reg[15], clear, clear_color};
`endif

  // A new scan address (or the start of active video) always wins the slot.
  always_comb begin
    slot_next = SLOT_IDLE;
    if (disp_en && ((disp_addr != last_rd_reg) || !en_d1_reg)) slot_next = SLOT_READ;
    else if (clear_busy)                                         slot_next = SLOT_CLEAR;
    else if (!fifo_empty)                                        slot_next = SLOT_WRITE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_addr_reg <= '0;
      we_n_reg      <= 1'b1;
      oe_n_reg      <= 1'b0;
      dq_out_reg    <= '0;
      dq_oe_reg     <= 1'b0;
      last_rd_reg   <= '0;
    end else begin
      case (slot_next)
        SLOT_CLEAR: begin
          sram_addr_reg <= clr_addr;
          dq_out_reg    <= clr_color;
          we_n_reg      <= 1'b0;
          oe_n_reg      <= 1'b1;
          dq_oe_reg     <= 1'b1;
        end
        SLOT_WRITE: begin
          sram_addr_reg <= fifo_head[ENT_W-1:16];
          dq_out_reg    <= fifo_head[15:0];
          we_n_reg      <= 1'b0;
          oe_n_reg      <= 1'b1;
          dq_oe_reg     <= 1'b1;
        end
        default: begin
          sram_addr_reg <= disp_addr;
          last_rd_reg   <= disp_addr;
          we_n_reg      <= 1'b1;
          oe_n_reg      <= 1'b0;
          dq_oe_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign sram_addr = sram_addr_reg;
  assign sram_we_n = we_n_reg;
  assign sram_oe_n = oe_n_reg;
  assign sram_dq   = dq_oe_reg ? dq_out_reg : 16'bz;

  // Pixel is held across write slots; a write never steals a slot from a new address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d1_reg      <= 1'b0;
      disp_valid_reg <= 1'b0;
      pix_reg        <= '0;
    end else begin
      en_d1_reg      <= disp_en;
      disp_valid_reg <= en_d1_reg;
      if (!oe_n_reg) pix_reg <= sram_dq;
    end
  end

  logic [9:0] chan [3];
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_expand
      logic [4:0] c;
      assign c        = pix_reg[gi*5 +: 5];
      assign chan[gi] = disp_valid_reg ? {c[4:1], {6{c[0]}}} : 10'd0;
    end
  endgenerate

  assign disp_b     = chan[0];
  assign disp_g     = chan[1];
  assign disp_r     = chan[2];
  assign disp_valid = disp_valid_reg;

endmodule

// File: tb/tb_sram_fb_port.sv
// Self-checking bench for sram_fb_port: default-size instance plus a small unscaled instance.
module tb_sram_fb_port;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- instance A: defaults (ADDR_W = 18) ----------------
  logic        disp_en_a = 0;
  logic [9:0]  disp_x_a = 0, disp_y_a = 0;
  logic [9:0]  disp_r_a, disp_g_a, disp_b_a;
  logic        disp_valid_a;
  logic        wr_valid_a = 0, wr_ready_a;
  logic [8:0]  wr_x_a = 0, wr_y_a = 0;
  logic [15:0] wr_data_a = 0;
  logic [17:0] sram_addr_a;
  wire  [15:0] sram_dq_a;
  logic        sram_we_n_a, sram_oe_n_a;
  logic        clear_a = 0;
  logic [15:0] clear_color_a = 0;
  logic        clear_busy_a;
  logic [15:0] mem_a [0:262143];

  sram_fb_port dut_a (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en_a), .disp_x(disp_x_a), .disp_y(disp_y_a),
    .disp_r(disp_r_a), .disp_g(disp_g_a), .disp_b(disp_b_a), .disp_valid(disp_valid_a),
    .wr_valid(wr_valid_a), .wr_ready(wr_ready_a), .wr_x(wr_x_a), .wr_y(wr_y_a), .wr_data(wr_data_a),
    .sram_addr(sram_addr_a), .sram_dq(sram_dq_a), .sram_we_n(sram_we_n_a), .sram_oe_n(sram_oe_n_a),
    .clear(clear_a), .clear_color(clear_color_a), .clear_busy(clear_busy_a)
  );
  assign sram_dq_a = (!sram_oe_n_a && sram_we_n_a) ? mem_a[sram_addr_a] : 16'bz;

  // ---------------- instance B: 4x4-bit coords, no scaling (ADDR_W = 8) ----------------
  logic        disp_en_b = 0;
  logic [3:0]  disp_x_b = 0, disp_y_b = 0;
  logic [9:0]  disp_r_b, disp_g_b, disp_b_b;
  logic        disp_valid_b;
  logic        wr_valid_b = 0, wr_ready_b;
  logic [3:0]  wr_x_b = 0, wr_y_b = 0;
  logic [15:0] wr_data_b = 0;
  logic [7:0]  sram_addr_b;
  wire  [15:0] sram_dq_b;
  logic        sram_we_n_b, sram_oe_n_b;
  logic        clear_b = 0;
  logic [15:0] clear_color_b = 0;
  logic        clear_busy_b;
  logic [15:0] mem_b [0:255];

  sram_fb_port #(.X_W(4), .Y_W(4), .SCALE_SHIFT(0), .FIFO_DEPTH(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .disp_en(disp_en_b), .disp_x(disp_x_b), .disp_y(disp_y_b),
    .disp_r(disp_r_b), .disp_g(disp_g_b), .disp_b(disp_b_b), .disp_valid(disp_valid_b),
    .wr_valid(wr_valid_b), .wr_ready(wr_ready_b), .wr_x(wr_x_b), .wr_y(wr_y_b), .wr_data(wr_data_b),
    .sram_addr(sram_addr_b), .sram_dq(sram_dq_b), .sram_we_n(sram_we_n_b), .sram_oe_n(sram_oe_n_b),
    .clear(clear_b), .clear_color(clear_color_b), .clear_busy(clear_busy_b)
  );
  assign sram_dq_b = (!sram_oe_n_b && sram_we_n_b) ? mem_b[sram_addr_b] : 16'bz;

  // Scoreboards: expected SRAM writes and expected display outputs
  logic [33:0] sb_a [$];
  logic [23:0] sb_b [$];
  logic [30:0] dq_exp [$];
  int  wr_cnt_a = 0, wr_cnt_b = 0;
  logic clear_phase = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] expand(input logic [4:0] c);
    return 10'((c >> 1) << 6) | (c[0] ? 10'd63 : 10'd0);
  endfunction

  function automatic logic [29:0] exp_rgb(input logic [15:0] p);
    return {expand(p[14:10]), expand(p[9:5]), expand(p[4:0])};
  endfunction

  // SRAM write monitors: update the memory model and pop the scoreboard
  initial forever begin
    @(negedge clk);
    if (rst_n && !sram_we_n_a) begin
      logic [33:0] e;
      mem_a[sram_addr_a] = sram_dq_a;
      wr_cnt_a++;
      e = (sb_a.size() > 0) ? sb_a.pop_front() : 34'bx;
      check("sram_write_a", {30'd0, sram_addr_a, sram_dq_a}, {30'd0, e});
      $display("write A addr=%05h data=%04h", sram_addr_a, sram_dq_a);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && !sram_we_n_b) begin
      mem_b[sram_addr_b] = sram_dq_b;
      wr_cnt_b++;
      if (!clear_phase) begin
        logic [23:0] e;
        e = (sb_b.size() > 0) ? sb_b.pop_front() : 24'bx;
        check("sram_write_b", {40'd0, sram_addr_b, sram_dq_b}, {40'd0, e});
        $display("write B addr=%02h data=%04h", sram_addr_b, sram_dq_b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic        prev_en = 0;
  logic [17:0] prev_addr = 0;

  task automatic disp_cycle(input logic en, input logic [9:0] x, input logic [9:0] y);
    logic [17:0] a;
    @(posedge clk); #1;
    if (prev_en) check("disp_addr", {46'd0, sram_addr_a}, {46'd0, prev_addr});
    if (dq_exp.size() == 2) begin
      logic [30:0] e;
      e = dq_exp.pop_front();
      check("disp_pixel", {33'd0, disp_valid_a, disp_r_a, disp_g_a, disp_b_a}, {33'd0, e});
      $display("pixel valid=%0b rgb=%03h/%03h/%03h", disp_valid_a, disp_r_a, disp_g_a, disp_b_a);
    end
    a = {x[9:1], y[9:1]};
    disp_en_a = en; disp_x_a = x; disp_y_a = y;
    dq_exp.push_back(en ? {1'b1, exp_rgb(mem_a[a])} : 31'd0);
    prev_en = en; prev_addr = a;
  endtask

  task automatic push_a(input logic [8:0] x, input logic [8:0] y, input logic [15:0] d);
    int c = 0;
    wr_valid_a = 1; wr_x_a = x; wr_y_a = y; wr_data_a = d;
    while (!wr_ready_a && c < 50) begin
      @(posedge clk); #1; c++;
    end
    check("push_a_ready", {63'd0, wr_ready_a}, 64'd1);
    @(posedge clk);
    sb_a.push_back({x, y, d});
    #1;
    wr_valid_a = 0;
  endtask

  initial begin
    int k, cnt, bad;
    logic acc;
    mem_a[0] = 16'h1234;
    mem_a[{9'd5, 9'd7}] = 16'h7FFF;
    mem_a[{9'd6, 9'd7}] = 16'h5A5A;
    for (int i = 0; i < 256; i++) mem_b[i] = 16'hAAAA;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_we_n",       {63'd0, sram_we_n_a}, 64'd1);
    check("rst_oe_n",       {63'd0, sram_oe_n_a}, 64'd0);
    check("rst_addr",       {46'd0, sram_addr_a}, 64'd0);
    check("rst_rgb",        {34'd0, disp_r_a, disp_g_a, disp_b_a}, 64'd0);
    check("rst_disp_valid", {63'd0, disp_valid_a}, 64'd0);
    check("rst_wr_ready",   {63'd0, wr_ready_a}, 64'd1);
    check("rst_clear_busy", {63'd0, clear_busy_a}, 64'd0);

    // Scan-out: two X share one scaled address, 2-cycle latency
    disp_cycle(0, 0, 0);
    disp_cycle(1, 10, 14);
    disp_cycle(1, 11, 14);
    disp_cycle(1, 12, 14);
    disp_cycle(1, 13, 14);
    disp_cycle(0, 14, 14);
    disp_cycle(1, 10, 14);
    disp_cycle(0, 0, 0);
    disp_cycle(0, 0, 0);
    disp_cycle(0, 0, 0);

    // Eight writes during blanking: all land in order
    cnt = wr_cnt_a;
    for (int i = 1; i <= 8; i++) push_a(9'(i * 3), 9'(i + 100), 16'(16'h1000 + i * 17));
    repeat (6) @(posedge clk);
    #1;
    check("a_writes_done", 64'(wr_cnt_a - cnt), 64'd8);
    check("a_sb_empty",    64'(sb_a.size()), 64'd0);

    // Unscaled instance: continuous active video stalls writes until blanking
    disp_y_b = 4'd3; disp_en_b = 1; k = 0; acc = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (acc) begin
        sb_b.push_back({4'(k), 4'(k + 3), 16'(16'hB000 + k)});
        k++;
      end
      disp_x_b = 4'(i);
      wr_valid_b = 1; wr_x_b = 4'(k); wr_y_b = 4'(k + 3); wr_data_b = 16'(16'hB000 + k);
      acc = wr_ready_b;
    end
    check("b_full_ready_low", {63'd0, wr_ready_b}, 64'd0);
    check("b_accepted",       64'(k), 64'd8);
    check("b_no_write_video", 64'(wr_cnt_b), 64'd0);
    disp_en_b = 0;
    for (int c = 0; c < 40 && wr_valid_b; c++) begin
      @(posedge clk); #1;
      if (acc) begin
        sb_b.push_back({4'(k), 4'(k + 3), 16'(16'hB000 + k)});
        k++;
        wr_valid_b = 0;
      end else begin
        acc = wr_ready_b;
      end
    end
    check("b_ninth_accepted", {63'd0, wr_valid_b}, 64'd0);
    repeat (14) @(posedge clk);
    #1;
    check("b_writes_total", 64'(wr_cnt_b), 64'd9);
    check("b_sb_empty",     64'(sb_b.size()), 64'd0);

    // Fill engine
    clear_color_b = 16'h001F; clear_b = 1;
    @(posedge clk); #1;
    clear_b = 0;
`ifdef FB_CLEAR_EN
    clear_phase = 1;
    check("clr_busy_rise",  {63'd0, clear_busy_b}, 64'd1);
    check("clr_ready_low",  {63'd0, wr_ready_b}, 64'd0);
    cnt = 0;
    while (clear_busy_b && cnt < 1000) begin
      @(posedge clk); #1; cnt++;
    end
    check("clr_busy_cycles", 64'(cnt), 64'd256);
    repeat (2) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem_b[i] !== 16'h001F) bad++;
    check("clr_mem_filled", 64'(bad), 64'd0);
    $display("clear done busy_cycles=%0d bad_words=%0d", cnt, bad);
    clear_phase = 0;
`else
    check("clr_disabled_busy",  {63'd0, clear_busy_b}, 64'd0);
    check("clr_disabled_ready", {63'd0, wr_ready_b}, 64'd1);
    bad = 0;
`endif

    // Reset during a write slot
    push_a(9'd20, 9'd21, 16'hC001);
    push_a(9'd22, 9'd23, 16'hC002);
    push_a(9'd24, 9'd25, 16'hC003);
    push_a(9'd26, 9'd27, 16'hC004);
    check("we_low_before_rst", {63'd0, sram_we_n_a}, 64'd0);
    rst_n = 0;
    #1;
    check("rst_async_we_n", {63'd0, sram_we_n_a}, 64'd1);
    check("rst_async_dq",   {48'd0, sram_dq_a}, {48'd0, mem_a[0]});
    sb_a.delete();
    cnt = wr_cnt_a;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("post_rst_ready", {63'd0, wr_ready_a}, 64'd1);
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_fifo_empty", 64'(wr_cnt_a - cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
